dds_sweep_ctrl: RTL and testbench

Frequency-sweep sequencer for the phase accumulator. It takes a start frequency, a step size, a step count and a dwell time. It then drives the accumulator's increment and load_increment inputs so the output frequency steps linearly: once, as a repeating sawtooth, or as an up/down triangle. It sits between the configuration registers and the phase accumulator, on sys_clk, and replaces the single-shot SPI frequency load whenever a sweep is active.

---
 rtl/dds_sweep_ctrl.sv | 149 ++++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: linear frequency-sweep sequencer driving the phase
// accumulator increment (single shot, sawtooth repeat or triangle repeat).
module dds_sweep_ctrl #(
    parameter int ACC_LENGTH   = 48,
    parameter int COUNT_LENGTH = 16,
    parameter int DWELL_LENGTH = 24
) (
    input  logic                    sys_clk,
    input  logic                    rst,
    input  logic [ACC_LENGTH-1:0]   start_freq,
    input  logic [ACC_LENGTH-1:0]   step_freq,
    input  logic [COUNT_LENGTH-1:0] step_count,
    input  logic [DWELL_LENGTH-1:0] dwell,
    input  logic [1:0]              mode,
    input  logic                    start,
    input  logic                    stop,
    output logic [ACC_LENGTH-1:0]   increment_out,
    output logic                    load_increment,
    output logic                    busy,
    output logic                    done,
    output logic [COUNT_LENGTH-1:0] step_index
);

    // state | meaning
    // IDLE  | waiting for start; outputs hold last increment/index
    // LOAD  | one-cycle load_increment strobe, dwell counter reloaded
    // DWELL | counting down the dwell time at the current index
    // DONE  | one-cycle done strobe after a single sweep completes
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DWELL = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_next;

    logic [ACC_LENGTH-1:0]   start_q;
    logic [ACC_LENGTH-1:0]   step_q;
    logic [COUNT_LENGTH-1:0] count_q;
    logic [DWELL_LENGTH-1:0] dwell_q;
    logic [DWELL_LENGTH-1:0] dwell_cnt;
    logic [1:0]              mode_q;
    logic                    down;

    logic accept;
    logic expire;
    logic at_top;
    logic repeat_mode;

    // stop always outranks a dwell expiry, and start is only honoured from IDLE
    assign accept      = (state == IDLE) && start && !stop;
    assign expire      = (state == DWELL) && (dwell_cnt == DWELL_LENGTH'(1)) && !stop;
    assign at_top      = !down && (step_index == count_q);
    assign repeat_mode = (mode_q == 2'b01) || (mode_q == 2'b10);

    // State register
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state decode and state-derived strobes
    always_comb begin
        state_next     = state;
        load_increment = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_next = LOAD;
            end
            LOAD: begin
                load_increment = 1'b1;
                busy           = 1'b1;
                state_next     = stop ? IDLE : DWELL;
            end
            DWELL: begin
                busy = 1'b1;
                if (stop)        state_next = IDLE;
                else if (expire) state_next = (at_top && !repeat_mode) ? DONE : LOAD;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Shadow copy of the sweep configuration, captured only on an accepted start
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            start_q <= '0;
            step_q  <= '0;
            count_q <= '0;
            dwell_q <= '0;
            mode_q  <= '0;
        end else if (accept) begin
            start_q <= start_freq;
            step_q  <= step_freq;
            count_q <= step_count;
            dwell_q <= (dwell == '0) ? DWELL_LENGTH'(1) : dwell;
            mode_q  <= mode;
        end
    end

    // Dwell down-counter: reloaded in LOAD, decremented in DWELL
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst)                  dwell_cnt <= '0;
        else if (state == LOAD)   dwell_cnt <= dwell_q;
        else if (state == DWELL)  dwell_cnt <= dwell_cnt - DWELL_LENGTH'(1);
    end

    // Sweep position: index, direction and increment advance on each dwell expiry
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            increment_out <= '0;
            step_index    <= '0;
            down          <= 1'b0;
        end else if (accept) begin
            increment_out <= start_freq;
            step_index    <= '0;
            down          <= 1'b0;
        end else if (expire) begin
            if (!down && (step_index < count_q)) begin
                increment_out <= increment_out + step_q;
                step_index    <= step_index + COUNT_LENGTH'(1);
            end else if (down && (step_index != '0)) begin
                increment_out <= increment_out - step_q;
                step_index    <= step_index - COUNT_LENGTH'(1);
            end else if (down) begin
                // triangle valley: turn around without repeating index 0
                down          <= 1'b0;
                step_index    <= COUNT_LENGTH'(1);
                increment_out <= increment_out + step_q;
            end else if ((mode_q == 2'b01) || ((mode_q == 2'b10) && (count_q == '0))) begin
                increment_out <= start_q;
                step_index    <= '0;
            end else if (mode_q == 2'b10) begin
                // triangle peak: turn around without repeating index N
                down          <= 1'b1;
                step_index    <= step_index - COUNT_LENGTH'(1);
                increment_out <= increment_out - step_q;
            end
        end
    end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Testbench for dds_sweep_ctrl: per-cycle comparison of all outputs against
// a closed-form model of the sweep (increment = start + index * step).
module tb_dds_sweep_ctrl;

    logic        sys_clk = 1'b0;
    logic        rst     = 1'b1;
    logic [47:0] start_freq = '0;
    logic [47:0] step_freq  = '0;
    logic [15:0] step_count = '0;
    logic [23:0] dwell      = '0;
    logic [1:0]  mode       = '0;
    logic        start      = 1'b0;
    logic        stop       = 1'b0;
    logic [47:0] increment_out;
    logic        load_increment;
    logic        busy;
    logic        done;
    logic [15:0] step_index;

    int checks = 0;
    int errors = 0;

    // active sweep configuration used by the model
    logic [47:0] cfg_start;
    logic [47:0] cfg_step;
    int          cfg_n;
    int          cfg_dwell;
    logic [1:0]  cfg_mode;
    int          cfg_stop;   // cycle during which stop is driven, 0 = never

    // observed {load, busy, done, index, increment} per cycle after start
    logic [66:0] obs [1:256];

    dds_sweep_ctrl dut (
        .sys_clk        (sys_clk),
        .rst            (rst),
        .start_freq     (start_freq),
        .step_freq      (step_freq),
        .step_count     (step_count),
        .dwell          (dwell),
        .mode           (mode),
        .start          (start),
        .stop           (stop),
        .increment_out  (increment_out),
        .load_increment (load_increment),
        .busy           (busy),
        .done           (done),
        .step_index     (step_index)
    );

    always #5 sys_clk = ~sys_clk;

    // Expected outputs in cycle c (c = 1 is the cycle after the start edge).
    function automatic logic [66:0] model(longint c);
        longint p, n, total, cc, k, m, idx;
        logic [47:0] inc;
        logic ld, bz, dn;
        bit single, frozen;
        n      = cfg_n;
        p      = ((cfg_dwell == 0) ? 1 : cfg_dwell) + 1;
        total  = (n + 1) * p;
        single = (cfg_mode == 2'b00) || (cfg_mode == 2'b11);
        frozen = (cfg_stop > 0) && (c > cfg_stop);
        cc     = frozen ? cfg_stop : c;
        ld = 1'b0; bz = 1'b0; dn = 1'b0;
        if (single && cc > total) begin
            idx = n;
            dn  = (cc == total + 1);
        end else begin
            k  = (cc - 1) / p;
            ld = ((cc - 1) % p == 0);
            bz = 1'b1;
            if (single)                idx = k;
            else if (cfg_mode == 2'b01) idx = k % (n + 1);
            else if (n == 0)           idx = 0;
            else begin
                m   = k % (2 * n);
                idx = (m <= n) ? m : 2 * n - m;
            end
        end
        inc = cfg_start + cfg_step * 48'(idx);
        if (frozen) begin
            ld = 1'b0; bz = 1'b0; dn = 1'b0;
        end
        return {ld, bz, dn, 16'(idx), inc};
    endfunction

    // Start a sweep with cfg_*, scramble the live config inputs every cycle,
    // optionally poke start while busy, and record outputs for `cycles` cycles.
    task automatic drive_sweep(int cycles, bit poke);
        longint p, total, lim;
        p     = ((cfg_dwell == 0) ? 1 : cfg_dwell) + 1;
        total = (cfg_n + 1) * p;
        lim   = ((cfg_mode == 2'b01) || (cfg_mode == 2'b10)) ? cycles : total + 1;
        if (cfg_stop > 0 && cfg_stop < lim) lim = cfg_stop;
        @(negedge sys_clk);
        start_freq = cfg_start;
        step_freq  = cfg_step;
        step_count = 16'(cfg_n);
        dwell      = 24'(cfg_dwell);
        mode       = cfg_mode;
        stop       = 1'b0;
        start      = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        for (int c = 1; c <= cycles; c++) begin
            obs[c]     = {load_increment, busy, done, step_index, increment_out};
            start_freq = 48'({$urandom(), $urandom()});
            step_freq  = 48'({$urandom(), $urandom()});
            step_count = 16'($urandom());
            dwell      = 24'($urandom());
            mode       = 2'($urandom());
            stop       = (c == cfg_stop);
            start      = poke && (c <= lim) && ($urandom_range(0, 3) == 0);
            @(negedge sys_clk);
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic test_reset();
        logic [66:0] got;
        rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        got = {load_increment, busy, done, step_index, increment_out};
        checks++;
        if (got !== 67'd0) begin
            errors++;
            $display("FAIL reset_held got %h exp 0", got);
        end
        rst = 1'b0;
        repeat (2) @(negedge sys_clk);
        got = {load_increment, busy, done, step_index, increment_out};
        checks++;
        if (got !== 67'd0) begin
            errors++;
            $display("FAIL reset_idle got %h exp 0", got);
        end
    endtask

    task automatic test_single();
        logic [66:0] exp_v;
        cfg_start = 48'h1000; cfg_step = 48'h100; cfg_n = 3; cfg_dwell = 4;
        cfg_mode = 2'b00; cfg_stop = 0;
        drive_sweep(24, 1'b1);
        for (int c = 1; c <= 24; c++) begin
            exp_v = model(c);
            checks++;
            if (obs[c] !== exp_v) begin
                errors++;
                $display("FAIL single c=%0d got %h exp %h", c, obs[c], exp_v);
            end
        end
        checks++;
        if (obs[16][47:0] !== 48'h1300 || obs[16][66] !== 1'b1) begin
            errors++;
            $display("FAIL single_last_strobe got %h exp strobe with 1300", obs[16]);
        end
        checks++;
        if (obs[21][64] !== 1'b1 || obs[21][65] !== 1'b0) begin
            errors++;
            $display("FAIL single_done got %h exp done=1 busy=0", obs[21]);
        end
    endtask

    task automatic test_triangle();
        logic [66:0] exp_v;
        cfg_start = 48'h10; cfg_step = 48'h1; cfg_n = 2; cfg_dwell = 1;
        cfg_mode = 2'b10; cfg_stop = 30;
        drive_sweep(30, 1'b1);
        for (int c = 1; c <= 30; c++) begin
            exp_v = model(c);
            checks++;
            if (obs[c] !== exp_v) begin
                errors++;
                $display("FAIL triangle c=%0d got %h exp %h", c, obs[c], exp_v);
            end
        end
        checks++;
        if (obs[7][63:0] !== {16'd1, 48'h11} || obs[9][63:0] !== {16'd0, 48'h10}) begin
            errors++;
            $display("FAIL triangle_descent got %h %h exp idx1/11 idx0/10", obs[7], obs[9]);
        end
    endtask

    task automatic test_sawtooth_wrap();
        logic [66:0] exp_v;
        cfg_start = 48'hFFFF_FFFF_FFFE; cfg_step = 48'h1; cfg_n = 3; cfg_dwell = 2;
        cfg_mode = 2'b01; cfg_stop = 28;
        drive_sweep(28, 1'b1);
        for (int c = 1; c <= 28; c++) begin
            exp_v = model(c);
            checks++;
            if (obs[c] !== exp_v) begin
                errors++;
                $display("FAIL sawtooth c=%0d got %h exp %h", c, obs[c], exp_v);
            end
        end
        checks++;
        if (obs[7][47:0] !== 48'h0 || obs[10][47:0] !== 48'h1 || obs[13][47:0] !== 48'hFFFF_FFFF_FFFE) begin
            errors++;
            $display("FAIL sawtooth_wrap got %h %h %h exp 0 1 FFFFFFFFFFFE",
                     obs[7][47:0], obs[10][47:0], obs[13][47:0]);
        end
    endtask

    task automatic test_edge_configs();
        logic [66:0] exp_v;
        // dwell 0 behaves as dwell 1
        cfg_start = 48'h500; cfg_step = 48'h20; cfg_n = 1; cfg_dwell = 0;
        cfg_mode = 2'b00; cfg_stop = 0;
        drive_sweep(8, 1'b0);
        for (int c = 1; c <= 8; c++) begin
            exp_v = model(c);
            checks++;
            if (obs[c] !== exp_v) begin
                errors++;
                $display("FAIL dwell0 c=%0d got %h exp %h", c, obs[c], exp_v);
            end
        end
        // N=0 single: one strobe, done two cycles later (mode 11 acts as single)
        cfg_start = 48'h777; cfg_step = 48'h3; cfg_n = 0; cfg_dwell = 1;
        cfg_mode = 2'b11; cfg_stop = 0;
        drive_sweep(6, 1'b1);
        for (int c = 1; c <= 6; c++) begin
            exp_v = model(c);
            checks++;
            if (obs[c] !== exp_v) begin
                errors++;
                $display("FAIL n0_single c=%0d got %h exp %h", c, obs[c], exp_v);
            end
        end
        checks++;
        if (obs[3][64] !== 1'b1 || obs[2][66] !== 1'b0) begin
            errors++;
            $display("FAIL n0_done got %h %h exp done at cycle 3", obs[2], obs[3]);
        end
        // N=0 sawtooth: start_freq reloaded every dwell period
        cfg_start = 48'h1234; cfg_step = 48'h9; cfg_n = 0; cfg_dwell = 2;
        cfg_mode = 2'b01; cfg_stop = 12;
        drive_sweep(12, 1'b0);
        for (int c = 1; c <= 12; c++) begin
            exp_v = model(c);
            checks++;
            if (obs[c] !== exp_v) begin
                errors++;
                $display("FAIL n0_saw c=%0d got %h exp %h", c, obs[c], exp_v);
            end
        end
    endtask

    task automatic test_stop();
        logic [66:0] exp_v;
        logic [66:0] got;
        // stop mid-dwell at step 2 (LOAD at c=11, dwell cycles 12..15)
        cfg_start = 48'h1000; cfg_step = 48'h100; cfg_n = 3; cfg_dwell = 4;
        cfg_mode = 2'b00; cfg_stop = 13;
        drive_sweep(30, 1'b1);
        for (int c = 1; c <= 30; c++) begin
            exp_v = model(c);
            checks++;
            if (obs[c] !== exp_v) begin
                errors++;
                $display("FAIL stop c=%0d got %h exp %h", c, obs[c], exp_v);
            end
        end
        // start together with stop in IDLE is ignored
        exp_v = model(100000);
        @(negedge sys_clk);
        start = 1'b1;
        stop  = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        stop  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            got = {load_increment, busy, done, step_index, increment_out};
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL start_stop_idle i=%0d got %h exp %h", i, got, exp_v);
            end
            @(negedge sys_clk);
        end
    endtask

    task automatic test_async_reset();
        logic [66:0] exp_v;
        logic [66:0] got;
        cfg_start = 48'hABCD; cfg_step = 48'h11; cfg_n = 4; cfg_dwell = 2;
        cfg_mode = 2'b10; cfg_stop = 0;
        drive_sweep(7, 1'b0);
        @(posedge sys_clk);
        #2 rst = 1'b1;
        #1;
        got = {load_increment, busy, done, step_index, increment_out};
        checks++;
        if (got !== 67'd0) begin
            errors++;
            $display("FAIL async_reset got %h exp 0", got);
        end
        @(negedge sys_clk);
        rst = 1'b0;
        cfg_start = 48'h2468_ACE0; cfg_step = 48'h5; cfg_n = 2; cfg_dwell = 3;
        cfg_mode = 2'b00; cfg_stop = 0;
        drive_sweep(15, 1'b1);
        for (int c = 1; c <= 15; c++) begin
            exp_v = model(c);
            checks++;
            if (obs[c] !== exp_v) begin
                errors++;
                $display("FAIL after_reset c=%0d got %h exp %h", c, obs[c], exp_v);
            end
        end
    endtask

    task automatic test_random();
        logic [66:0] exp_v;
        int cyc;
        for (int t = 0; t < 10; t++) begin
            cfg_start = 48'({$urandom(), $urandom()});
            cfg_step  = 48'({$urandom(), $urandom()});
            cfg_n     = $urandom_range(0, 5);
            cfg_dwell = $urandom_range(0, 4);
            cfg_mode  = 2'($urandom_range(0, 3));
            if (cfg_mode == 2'b01 || cfg_mode == 2'b10) begin
                cyc      = $urandom_range(30, 60);
                cfg_stop = cyc;
            end else begin
                cyc      = (cfg_n + 1) * (((cfg_dwell == 0) ? 1 : cfg_dwell) + 1) + 3;
                cfg_stop = ($urandom_range(0, 1) == 1) ? $urandom_range(1, cyc - 3) : 0;
            end
            drive_sweep(cyc, 1'b1);
            for (int c = 1; c <= cyc; c++) begin
                exp_v = model(c);
                checks++;
                if (obs[c] !== exp_v) begin
                    errors++;
                    $display("FAIL random t=%0d mode=%0d c=%0d got %h exp %h",
                             t, cfg_mode, c, obs[c], exp_v);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_triangle();
        test_sawtooth_wrap();
        test_edge_configs();
        test_stop();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
